mac_ws_pe: RTL and testbench

MAC_WS_PE -- requirements
Module: mac_ws_pe

---
 rtl/mac_pkg.sv | 14 +
 rtl/mac_sat_add.sv | 38 +++
 rtl/mac_ws_pe.sv | 96 +++++++++
 tb/tb_mac_ws_pe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared width defaults and saturation limits for the weight-stationary MAC processing element.
package mac_pkg;

  localparam int IFMAP_BITWIDTH_DEF = 16;
  localparam int W_BITWIDTH_DEF     = 8;
  localparam int OFMAP_BITWIDTH_DEF = 32;
  localparam int PROD_BITWIDTH_DEF  = IFMAP_BITWIDTH_DEF + W_BITWIDTH_DEF;

  localparam logic [OFMAP_BITWIDTH_DEF-1:0] OFMAP_SAT_MAX =
    {1'b0, {(OFMAP_BITWIDTH_DEF-1){1'b1}}};
  localparam logic [OFMAP_BITWIDTH_DEF-1:0] OFMAP_SAT_MIN =
    {1'b1, {(OFMAP_BITWIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/mac_sat_add.sv
// Widened signed add of product and partial sum with overflow detect and clamp-or-wrap result.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int PROD_BITWIDTH  = PROD_BITWIDTH_DEF,
  parameter int OFMAP_BITWIDTH = OFMAP_BITWIDTH_DEF,
  parameter int SATURATE       = 1
) (
  input  logic [PROD_BITWIDTH-1:0]  product,
  input  logic [OFMAP_BITWIDTH-1:0] addend,
  output logic [OFMAP_BITWIDTH-1:0] result,
  output logic                      overflow
);

  localparam int EXT_BITS = OFMAP_BITWIDTH + 1 - PROD_BITWIDTH;

  localparam logic [OFMAP_BITWIDTH-1:0] SAT_MAX = {1'b0, {(OFMAP_BITWIDTH-1){1'b1}}};
  localparam logic [OFMAP_BITWIDTH-1:0] SAT_MIN = {1'b1, {(OFMAP_BITWIDTH-1){1'b0}}};

  logic [OFMAP_BITWIDTH:0] prod_ext;
  logic [OFMAP_BITWIDTH:0] add_ext;
  logic [OFMAP_BITWIDTH:0] sum;

  assign prod_ext = {{EXT_BITS{product[PROD_BITWIDTH-1]}}, product};
  assign add_ext  = {addend[OFMAP_BITWIDTH-1], addend};
  assign sum      = prod_ext + add_ext;

  // One guard bit is enough: the two top bits disagree exactly when the sum leaves the range.
  assign overflow = sum[OFMAP_BITWIDTH] ^ sum[OFMAP_BITWIDTH-1];

  always_comb begin
    result = sum[OFMAP_BITWIDTH-1:0];
    if ((SATURATE != 0) && overflow) begin
      result = sum[OFMAP_BITWIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/mac_ws_pe.sv
// Weight-stationary MAC processing element: double-buffered weight, registered operand
// forwarding and a one-cycle multiply-accumulate into the partial-sum chain.
module mac_ws_pe
  import mac_pkg::*;
#(
  parameter int IFMAP_BITWIDTH = IFMAP_BITWIDTH_DEF,
  parameter int W_BITWIDTH     = W_BITWIDTH_DEF,
  parameter int OFMAP_BITWIDTH = OFMAP_BITWIDTH_DEF,
  parameter int SATURATE       = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      w_load_in,
  input  logic [W_BITWIDTH-1:0]     w_data_in,
  output logic                      w_load_out,
  output logic [W_BITWIDTH-1:0]     w_data_out,
  input  logic                      w_swap_in,
  output logic                      w_swap_out,
  input  logic                      ifmap_valid_in,
  input  logic [IFMAP_BITWIDTH-1:0] ifmap_data_in,
  output logic                      ifmap_valid_out,
  output logic [IFMAP_BITWIDTH-1:0] ifmap_data_out,
  input  logic                      MAC_valid_in,
  input  logic [OFMAP_BITWIDTH-1:0] MAC_data_in,
  output logic                      MAC_valid_out,
  output logic [OFMAP_BITWIDTH-1:0] MAC_data_out,
  output logic                      sat_flag_out
);

  localparam int PROD_BITWIDTH = IFMAP_BITWIDTH + W_BITWIDTH;

  logic [W_BITWIDTH-1:0]     shadow_w;
  logic [W_BITWIDTH-1:0]     active_w;
  logic [PROD_BITWIDTH-1:0]  w_ext;
  logic [PROD_BITWIDTH-1:0]  x_ext;
  logic [PROD_BITWIDTH-1:0]  product;
  logic [OFMAP_BITWIDTH-1:0] addend;
  logic [OFMAP_BITWIDTH-1:0] mac_result;
  logic                      mac_overflow;

  assign w_data_out = shadow_w;

  // Both operands widened to the full product width so the low bits of the
  // unsigned multiply equal the signed product.
  assign w_ext   = {{IFMAP_BITWIDTH{active_w[W_BITWIDTH-1]}}, active_w};
  assign x_ext   = {{W_BITWIDTH{ifmap_data_in[IFMAP_BITWIDTH-1]}}, ifmap_data_in};
  assign product = w_ext * x_ext;
  assign addend  = MAC_valid_in ? MAC_data_in : '0;

  mac_sat_add #(
    .PROD_BITWIDTH  (PROD_BITWIDTH),
    .OFMAP_BITWIDTH (OFMAP_BITWIDTH),
    .SATURATE       (SATURATE)
  ) u_sat_add (
    .product  (product),
    .addend   (addend),
    .result   (mac_result),
    .overflow (mac_overflow)
  );

  // Active takes the pre-edge shadow, so a load and swap together move the old weight in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_w   <= '0;
      active_w   <= '0;
      w_load_out <= 1'b0;
      w_swap_out <= 1'b0;
    end else begin
      w_load_out <= w_load_in;
      w_swap_out <= w_swap_in;
      if (w_load_in) shadow_w <= w_data_in;
      if (w_swap_in) active_w <= shadow_w;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifmap_valid_out <= 1'b0;
      ifmap_data_out  <= '0;
      MAC_valid_out   <= 1'b0;
      MAC_data_out    <= '0;
      sat_flag_out    <= 1'b0;
    end else begin
      ifmap_valid_out <= ifmap_valid_in;
      MAC_valid_out   <= ifmap_valid_in;
      if (ifmap_valid_in) begin
        ifmap_data_out <= ifmap_data_in;
        MAC_data_out   <= mac_result;
        sat_flag_out   <= mac_overflow;
      end else begin
        sat_flag_out   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_ws_pe.sv
// Bench for mac_ws_pe: saturating and wrapping instances driven in parallel, checked
// against an arithmetic reference model with directed and random steps.
module tb_mac_ws_pe;

  localparam longint OMAX = (longint'(1) <<< 31) - 1;
  localparam longint OMIN = -(longint'(1) <<< 31);

  logic clk = 1'b0;
  logic rstn;
  logic w_load_in, w_swap_in, ifmap_valid_in, MAC_valid_in;
  logic [7:0]  w_data_in;
  logic [15:0] ifmap_data_in;
  logic [31:0] MAC_data_in;

  logic s_wlo, s_swo, s_ivo, s_mvo, s_sf;
  logic [7:0] s_wdo; logic [15:0] s_ido; logic [31:0] s_mdo;
  logic w_wlo, w_swo, w_ivo, w_mvo, w_sf;
  logic [7:0] w_wdo; logic [15:0] w_ido; logic [31:0] w_mdo;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_shadow, m_active;
  logic        m_wlo, m_swo, m_ivo, m_mvo, m_sf_s, m_sf_w;
  logic [15:0] m_ido;
  logic [31:0] m_mdo_s, m_mdo_w;

  always #5 clk = ~clk;

  mac_ws_pe #(.IFMAP_BITWIDTH(16), .W_BITWIDTH(8), .OFMAP_BITWIDTH(32), .SATURATE(1)) u_sat (
    .clk(clk), .rstn(rstn),
    .w_load_in(w_load_in), .w_data_in(w_data_in), .w_load_out(s_wlo), .w_data_out(s_wdo),
    .w_swap_in(w_swap_in), .w_swap_out(s_swo),
    .ifmap_valid_in(ifmap_valid_in), .ifmap_data_in(ifmap_data_in),
    .ifmap_valid_out(s_ivo), .ifmap_data_out(s_ido),
    .MAC_valid_in(MAC_valid_in), .MAC_data_in(MAC_data_in),
    .MAC_valid_out(s_mvo), .MAC_data_out(s_mdo), .sat_flag_out(s_sf)
  );

  mac_ws_pe #(.IFMAP_BITWIDTH(16), .W_BITWIDTH(8), .OFMAP_BITWIDTH(32), .SATURATE(0)) u_wrap (
    .clk(clk), .rstn(rstn),
    .w_load_in(w_load_in), .w_data_in(w_data_in), .w_load_out(w_wlo), .w_data_out(w_wdo),
    .w_swap_in(w_swap_in), .w_swap_out(w_swo),
    .ifmap_valid_in(ifmap_valid_in), .ifmap_data_in(ifmap_data_in),
    .ifmap_valid_out(w_ivo), .ifmap_data_out(w_ido),
    .MAC_valid_in(MAC_valid_in), .MAC_data_in(MAC_data_in),
    .MAC_valid_out(w_mvo), .MAC_data_out(w_mdo), .sat_flag_out(w_sf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_mac(input longint w, input longint x, input longint add,
                                  input bit sat, output logic [31:0] res, output logic ovf);
    longint s;
    s   = w * x + add;
    ovf = (s > OMAX) || (s < OMIN);
    if (ovf && sat) res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    else            res = s[31:0];
  endfunction

  task automatic model_reset();
    m_shadow = '0; m_active = '0;
    m_wlo = 0; m_swo = 0; m_ivo = 0; m_mvo = 0; m_sf_s = 0; m_sf_w = 0;
    m_ido = '0; m_mdo_s = '0; m_mdo_w = '0;
  endtask

  task automatic check_all(input string ph);
    chk({ph, ".s_wlo"}, 32'(s_wlo), 32'(m_wlo));
    chk({ph, ".s_wdo"}, 32'(s_wdo), 32'(m_shadow));
    chk({ph, ".s_swo"}, 32'(s_swo), 32'(m_swo));
    chk({ph, ".s_ivo"}, 32'(s_ivo), 32'(m_ivo));
    chk({ph, ".s_ido"}, 32'(s_ido), 32'(m_ido));
    chk({ph, ".s_mvo"}, 32'(s_mvo), 32'(m_mvo));
    chk({ph, ".s_mdo"}, s_mdo, m_mdo_s);
    chk({ph, ".s_sf"},  32'(s_sf),  32'(m_sf_s));
    chk({ph, ".w_wdo"}, 32'(w_wdo), 32'(m_shadow));
    chk({ph, ".w_mvo"}, 32'(w_mvo), 32'(m_mvo));
    chk({ph, ".w_mdo"}, w_mdo, m_mdo_w);
    chk({ph, ".w_sf"},  32'(w_sf),  32'(m_sf_w));
  endtask

  // Drive one clock of inputs, advance the model, then compare just after the edge.
  task automatic cycle(input string ph, input bit ld, input logic [7:0] wd, input bit sw,
                       input bit iv, input logic [15:0] id, input bit mv, input logic [31:0] md);
    logic [31:0] r_s, r_w;
    logic f_s, f_w;
    longint add;
    w_load_in = ld; w_data_in = wd; w_swap_in = sw;
    ifmap_valid_in = iv; ifmap_data_in = id; MAC_valid_in = mv; MAC_data_in = md;
    add = mv ? longint'($signed(md)) : 0;
    ref_mac(longint'($signed(m_active)), longint'($signed(id)), add, 1'b1, r_s, f_s);
    ref_mac(longint'($signed(m_active)), longint'($signed(id)), add, 1'b0, r_w, f_w);
    if (iv) begin
      m_mdo_s = r_s; m_sf_s = f_s; m_mdo_w = r_w; m_sf_w = f_w; m_ido = id;
    end else begin
      m_sf_s = 0; m_sf_w = 0;
    end
    m_ivo = iv; m_mvo = iv; m_wlo = ld; m_swo = sw;
    if (sw) m_active = m_shadow;
    if (ld) m_shadow = wd;
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic idle_inputs();
    w_load_in = 0; w_data_in = '0; w_swap_in = 0;
    ifmap_valid_in = 0; ifmap_data_in = '0; MAC_valid_in = 0; MAC_data_in = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] md;
    // Reset with every input nonzero: outputs must be zero before and across edges.
    rstn = 0;
    w_load_in = 1; w_data_in = 8'h5A; w_swap_in = 1;
    ifmap_valid_in = 1; ifmap_data_in = 16'h1234; MAC_valid_in = 1; MAC_data_in = 32'h0BAD_F00D;
    model_reset();
    #2;
    check_all("rst0");
    repeat (2) @(posedge clk);
    #1;
    check_all("rst1");
    chk("rst_mdo", s_mdo, 32'h0);
    idle_inputs();
    rstn = 1;

    // Load 5, swap, then 5*3+10.
    cycle("ld5", 1, 8'd5, 0, 0, '0, 0, '0);
    chk("ld5_wdo", 32'(s_wdo), 32'd5);
    chk("ld5_wlo", 32'(s_wlo), 32'd1);
    cycle("sw5", 0, '0, 1, 0, '0, 0, '0);
    chk("sw5_wlo", 32'(s_wlo), 32'd0);
    chk("sw5_swo", 32'(s_swo), 32'd1);
    cycle("mac25", 0, '0, 0, 1, 16'd3, 1, 32'd10);
    chk("mac25_val", s_mdo, 32'd25);
    chk("mac25_vld", 32'(s_mvo), 32'd1);

    // Load 7 with swap: active takes old shadow 5.
    cycle("ldsw", 1, 8'd7, 1, 0, '0, 0, '0);
    cycle("mac10", 0, '0, 0, 1, 16'd2, 1, 32'd0);
    chk("mac10_val", s_mdo, 32'd10);
    cycle("sw7", 0, '0, 1, 0, '0, 0, '0);
    cycle("mac14", 0, '0, 0, 1, 16'd2, 1, 32'd0);
    chk("mac14_val", s_mdo, 32'd14);

    // Positive overflow.
    cycle("ldm128", 1, 8'h80, 0, 0, '0, 0, '0);
    cycle("swm128", 0, '0, 1, 0, '0, 0, '0);
    cycle("povf", 0, '0, 0, 1, 16'h8000, 1, 32'h7FFF_FFFF);
    chk("povf_sat", s_mdo, 32'h7FFF_FFFF);
    chk("povf_sflag", 32'(s_sf), 32'd1);
    chk("povf_wrap", w_mdo, 32'h803F_FFFF);
    chk("povf_wflag", 32'(w_sf), 32'd1);

    // Negative overflow.
    cycle("ld127", 1, 8'd127, 0, 0, '0, 0, '0);
    cycle("sw127", 0, '0, 1, 0, '0, 0, '0);
    cycle("novf", 0, '0, 0, 1, 16'h8000, 1, 32'h8000_0000);
    chk("novf_sat", s_mdo, 32'h8000_0000);
    chk("novf_sflag", 32'(s_sf), 32'd1);
    chk("novf_wrap", w_mdo, 32'h7FC0_8000);

    // MAC_valid_in low ignores the addend; idle cycles hold the result.
    cycle("ld5b", 1, 8'd5, 0, 0, '0, 0, '0);
    cycle("sw5b", 0, '0, 1, 0, '0, 0, '0);
    cycle("mac15", 0, '0, 0, 1, 16'd3, 0, 32'd999);
    chk("mac15_val", s_mdo, 32'd15);
    for (int i = 0; i < 3; i++) cycle("hold", 0, '0, 0, 0, 16'hFFFF, 1, 32'd1);
    chk("hold_val", s_mdo, 32'd15);
    chk("hold_ido", 32'(s_ido), 32'd3);
    chk("hold_vld", 32'(s_mvo), 32'd0);
    chk("hold_sf", 32'(s_sf), 32'd0);

    // Swap on a compute cycle only affects the following compute.
    cycle("ld9", 1, 8'd9, 0, 0, '0, 0, '0);
    cycle("swc", 0, '0, 1, 1, 16'd4, 0, '0);
    chk("swc_old", s_mdo, 32'd20);
    cycle("macn", 0, '0, 0, 1, 16'd4, 0, '0);
    chk("macn_new", s_mdo, 32'd36);

    // Random traffic with an asynchronous reset in the middle.
    for (int n = 0; n < 300; n++) begin
      if (n == 150) begin
        #2;
        rstn = 0;
        model_reset();
        #1;
        check_all("midrst");
        chk("midrst_mdo", s_mdo, 32'h0);
        @(posedge clk);
        #1;
        check_all("midrst_hold");
        rstn = 1;
        cycle("postrst", 0, '0, 0, 1, 16'd1234, 1, 32'd77);
        chk("postrst_val", s_mdo, 32'd77);
      end
      case ($urandom_range(0, 3))
        0:       md = 32'h7FFF_FFFF - $urandom_range(0, 32'h0040_0000);
        1:       md = 32'h8000_0000 + $urandom_range(0, 32'h0040_0000);
        default: md = $urandom;
      endcase
      cycle("rnd", ($urandom_range(0, 3) == 0), 8'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom),
            ($urandom_range(0, 1) == 1), md);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
